// File: rtl/timer_apb_master_if.sv
// Command/response channel plus APB3 bus between a sequencer, timer_apb_master and its responder.
// master: the requester block's view; slave: the view of whatever surrounds it (sequencer and responder).
interface timer_apb_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/timer_apb_master.sv
// APB3 requester: one command-channel request becomes one APB transfer and one response pulse.
// Optional ACCESS-phase timeout enabled by defining TIMER_APB_MASTER_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | no transfer; req_ready=1, request captured on accept
//  SETUP  | psel=1, penable=0 for one cycle
//  ACCESS | psel=1, penable=1 until pready (or timeout)
module timer_apb_master #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  timer_apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
    $error("timer_apb_master: TIMEOUT_CYC must be at least 1");
  end

`ifdef TIMER_APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef TIMER_APB_MASTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state    <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= bus.req_write;
            paddr_q  <= bus.req_addr;
            pwdata_q <= bus.req_write ? bus.req_wdata : '0;
`ifdef TIMER_APB_MASTER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // pready on the timeout edge still counts as a normal completion
          if (bus.pready) begin
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q   <= bus.pslverr;
          end
`ifdef TIMER_APB_MASTER_TIMEOUT_EN
          else if (wait_cnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state     <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_timer_apb_master.sv
// Bench for timer_apb_master: directed timer-register cases plus randomized transfers,
// every cycle checked against a transfer-level model (latency = 3 + wait states, or timeout).
module tb_timer_apb_master;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TO_CYC = 16;
`ifdef TIMER_APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [DATA_W-1:0] last_rdata = '0;
  logic              last_err = 1'b0;

  timer_apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  timer_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus_if)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic rand_responder();
    bus_if.pready  = 1'($urandom);
    bus_if.prdata  = 8'($urandom);
    bus_if.pslverr = 1'($urandom);
  endtask

  task automatic idle_cycle();
    @(negedge pclk);
    chk("idle_rsp_valid", bus_if.rsp_valid, 0);
    chk("idle_rsp_rdata_hold", bus_if.rsp_rdata, last_rdata);
    chk("idle_rsp_err_hold", bus_if.rsp_err, last_err);
    chk("idle_psel", bus_if.psel, 0);
    chk("idle_penable", bus_if.penable, 0);
    chk("idle_req_ready", bus_if.req_ready, 1);
    rand_responder();
  endtask

  // Called at a negedge of an IDLE cycle; returns at the negedge of the response cycle.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                      input int waits, input logic [7:0] rd, input bit er);
    bit          to;
    int          n_acc;
    logic [7:0]  exp_wd;
    to     = TO_EN && (waits >= TO_CYC);
    n_acc  = to ? TO_CYC : waits + 1;
    exp_wd = w ? d : 8'h00;

    chk("req_ready_before", bus_if.req_ready, 1);
    chk("busy_before", bus_if.busy, 0);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = w;
    bus_if.req_addr  = a;
    bus_if.req_wdata = d;
    rand_responder();

    @(negedge pclk);
    chk("setup_psel", bus_if.psel, 1);
    chk("setup_penable", bus_if.penable, 0);
    chk("setup_paddr", bus_if.paddr, a);
    chk("setup_pwrite", bus_if.pwrite, w);
    chk("setup_pwdata", bus_if.pwdata, exp_wd);
    chk("setup_busy", bus_if.busy, 1);
    chk("setup_req_ready", bus_if.req_ready, 0);
    chk("setup_rsp_valid", bus_if.rsp_valid, 0);
    bus_if.req_valid = 1'($urandom);
    bus_if.req_write = 1'($urandom);
    bus_if.req_addr  = 8'($urandom);
    bus_if.req_wdata = 8'($urandom);
    rand_responder();

    for (int k = 0; k < n_acc; k++) begin
      @(negedge pclk);
      chk("access_psel", bus_if.psel, 1);
      chk("access_penable", bus_if.penable, 1);
      chk("access_paddr", bus_if.paddr, a);
      chk("access_pwrite", bus_if.pwrite, w);
      chk("access_pwdata", bus_if.pwdata, exp_wd);
      chk("access_rsp_valid", bus_if.rsp_valid, 0);
      chk("access_req_ready", bus_if.req_ready, 0);
      bus_if.pready  = (k == waits);
      bus_if.prdata  = (k == waits) ? rd : 8'($urandom);
      bus_if.pslverr = (k == waits) ? er : 1'($urandom);
    end

    @(negedge pclk);
    last_rdata = (to || w) ? 8'h00 : rd;
    last_err   = to ? 1'b1 : er;
    chk("rsp_valid", bus_if.rsp_valid, 1);
    chk("rsp_rdata", bus_if.rsp_rdata, last_rdata);
    chk("rsp_err", bus_if.rsp_err, last_err);
    chk("rsp_psel", bus_if.psel, 0);
    chk("rsp_penable", bus_if.penable, 0);
    chk("rsp_busy", bus_if.busy, 0);
    chk("rsp_paddr_hold", bus_if.paddr, a);
    chk("rsp_pwdata_hold", bus_if.pwdata, exp_wd);
    bus_if.req_valid = 1'b0;
    rand_responder();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         w, er;
    logic [7:0] a, d, rd;
    int         waits, gap;

    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.prdata    = '0;
    bus_if.pready    = 1'b0;
    bus_if.pslverr   = 1'b0;

    repeat (3) @(negedge pclk);
    chk("rst_psel", bus_if.psel, 0);
    chk("rst_penable", bus_if.penable, 0);
    chk("rst_pwrite", bus_if.pwrite, 0);
    chk("rst_paddr", bus_if.paddr, 0);
    chk("rst_pwdata", bus_if.pwdata, 0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 0);
    chk("rst_rsp_err", bus_if.rsp_err, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_req_ready", bus_if.req_ready, 1);
    presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_psel", bus_if.psel, 0);
    chk("post_rst_req_ready", bus_if.req_ready, 1);

    // zero-wait write to TCR
    xfer(1'b1, 8'h01, 8'h35, 0, 8'hFF, 1'b0);
    idle_cycle();
    // wait-state read of TDR
    xfer(1'b0, 8'h00, 8'h00, 3, 8'hA7, 1'b0);
    idle_cycle();
    // error on reserved address, then read accepted in the response cycle
    xfer(1'b1, 8'h07, 8'h5A, 0, 8'h00, 1'b1);
    xfer(1'b0, 8'h02, 8'h00, 1, 8'h5C, 1'b0);
    idle_cycle();
    // long stall: times out only when the timeout feature is built in
    xfer(1'b0, 8'h03, 8'h00, 20, 8'h3C, 1'b0);
    idle_cycle();
    // pready arriving on the last allowed ACCESS cycle
    xfer(1'b0, 8'h03, 8'h00, TO_CYC - 1, 8'h96, 1'b0);
    idle_cycle();

    // reset while in ACCESS
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 8'h03;
    bus_if.pready    = 1'b0;
    @(negedge pclk);
    bus_if.req_valid = 1'b0;
    @(negedge pclk);
    chk("abort_penable_before", bus_if.penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("abort_psel", bus_if.psel, 0);
    chk("abort_penable", bus_if.penable, 0);
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_req_ready", bus_if.req_ready, 1);
    chk("abort_paddr", bus_if.paddr, 0);
    @(negedge pclk);
    presetn    = 1'b1;
    last_rdata = '0;
    last_err   = 1'b0;
    repeat (4) idle_cycle();

    for (int i = 0; i < 40; i++) begin
      w     = 1'($urandom);
      a     = 8'($urandom);
      d     = 8'($urandom);
      rd    = 8'($urandom);
      er    = ($urandom_range(0, 3) == 0);
      waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20))
                                          : int'($urandom_range(0, 4));
      xfer(w, a, d, waits, rd, er);
      gap = int'($urandom_range(0, 2));
      repeat (gap) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
